// File: rtl/ysyx_lsu_sram_resp.sv
// Word-organised SRAM responder for the LSU bus: one outstanding load or store,
// programmable latency, single-cycle rvalid/wready pulse qualified by lsu_err.
module ysyx_lsu_sram_resp #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                RD_LAT     = 2,
  parameter int                WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_err
);

  localparam int CNT_W = 8;
  localparam logic [ADDR_W:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] ADDR_HI = ADDR_LO + ((ADDR_W+1)'(1) << (DEPTH_LOG2 + 2));

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic [3:0]          req_strb;
  logic                cap_wr, cap_rd, commit;
  logic                rvalid_nxt, wready_nxt, err_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];

  logic [1:0]            off;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  misalign, out_range, req_err;
  logic [3:0]            sh_strb;
  logic [DATA_W-1:0]     sh_data;
  logic                  unused_strb_hi;

  // Only 1/3/f strobes exist on this port; the upper strobe bits carry nothing.
  assign unused_strb_hi = ^{lsu_wstrb[7:4], lsu_rstrb[7:4]};

  assign off       = req_addr[1:0];
  assign widx      = req_addr[DEPTH_LOG2+1:2];
  assign misalign  = (req_strb == 4'h3 && off == 2'd3) || (req_strb == 4'hf && off != 2'd0);
  assign out_range = ({1'b0, req_addr} < ADDR_LO) || ({1'b0, req_addr} >= ADDR_HI);
  assign req_err   = misalign || out_range;
  assign sh_strb   = req_strb << off;
  assign sh_data   = req_data << {off, 3'b000};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_wr     = 1'b0;
    cap_rd     = 1'b0;
    commit     = 1'b0;
    rvalid_nxt = 1'b0;
    wready_nxt = 1'b0;
    err_nxt    = 1'b0;
    rdata_nxt  = lsu_rdata;
    case (state)
      IDLE: begin
        // Write wins a tie; a held arvalid is picked up on the next IDLE cycle.
        if (lsu_awvalid && lsu_wvalid) begin
          cap_wr    = 1'b1;
          cnt_nxt   = CNT_W'(WR_LAT - 1);
          state_nxt = WR_WAIT;
        end else if (lsu_arvalid) begin
          cap_rd    = 1'b1;
          cnt_nxt   = CNT_W'(RD_LAT - 1);
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          rvalid_nxt = 1'b1;
          err_nxt    = req_err;
          rdata_nxt  = req_err ? '0 : mem[widx];
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt == '0) begin
          wready_nxt = 1'b1;
          err_nxt    = req_err;
          commit     = !req_err && !rst;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      req_strb   <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
      lsu_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lsu_rvalid <= rvalid_nxt;
      lsu_wready <= wready_nxt;
      lsu_err    <= err_nxt;
      lsu_rdata  <= rdata_nxt;
      if (cap_wr) begin
        req_addr <= lsu_awaddr;
        req_data <= lsu_wdata;
        req_strb <= lsu_wstrb[3:0];
      end else if (cap_rd) begin
        req_addr <= lsu_araddr;
        req_strb <= lsu_rstrb[3:0];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (sh_strb[b]) mem[widx][8*b +: 8] <= sh_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_sram_resp.sv
// Directed vector bench for ysyx_lsu_sram_resp: table of loads/stores with
// hand-computed results plus sequences for write/read collision and mid-write reset.
module tb_ysyx_lsu_sram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lsu_araddr = '0;
  logic        lsu_arvalid = 1'b0;
  logic [7:0]  lsu_rstrb = '0;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr = '0;
  logic        lsu_awvalid = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [7:0]  lsu_wstrb = '0;
  logic        lsu_wvalid = 1'b0;
  logic        lsu_wready;
  logic        lsu_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_lsu_sram_resp dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_err(lsu_err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Call just after an active edge; returns edges from acceptance to pulse (-1 on timeout).
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [7:0] strb, output logic [31:0] rd, output bit err,
                       output int lat);
    lat = -1;
    rd  = '0;
    err = 1'b0;
    if (wr) begin
      lsu_awaddr = addr; lsu_wdata = data; lsu_wstrb = strb;
      lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    end else begin
      lsu_araddr = addr; lsu_rstrb = strb; lsu_arvalid = 1'b1;
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if ((wr && lsu_wready) || (!wr && lsu_rvalid)) begin
        lat = n; rd = lsu_rdata; err = lsu_err;
        break;
      end
    end
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_arvalid = 1'b0;
    if (lat < 0) check("timeout", 32'hffff_ffff, 32'h0);
    @(posedge clk); #1;
    check("pulse_clear", {29'd0, lsu_rvalid, lsu_wready, lsu_err}, 32'h0);
  endtask

  vec_t        vecs[16];
  logic [31:0] rd;
  bit          err;
  int          lat;
  int          gap;

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hA5A5_1234, 8'h0f, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         8'h0f, 32'hA5A5_1234, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 8'h0f, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0023, 32'h0000_0077, 8'h01, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         8'h0f, 32'h7722_3344, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0012, 32'h0000_BEEF, 8'h03, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0,         8'h0f, 32'hBEEF_1234, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0f, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0002, 32'h5555_5555, 8'h0f, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         8'h0f, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b0, 32'h1000_0000, 32'h0,         8'h0f, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'h8000_0013, 32'h0000_4444, 8'h03, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h8000_0011, 32'h0,         8'h01, 32'hBEEF_1234, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_0FFC, 32'h0BAD_BEEF, 8'h0f, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0FFF, 32'h0,         8'h01, 32'h0BAD_BEEF, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_1000, 32'h0,         8'h0f, 32'h0, 1'b1};

    #3;
    check("reset_outputs", {lsu_rdata[27:0], lsu_rvalid, lsu_wready, lsu_err, 1'b0}, 32'h0);
    check("reset_rdata", lsu_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), vecs[i].wr ? 32'd1 : 32'd2);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Write and read raised together: write first, read RD_LAT+1 edges later.
    lsu_awaddr = 32'h8000_0030; lsu_wdata = 32'h1357_9BDF; lsu_wstrb = 8'h0f;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    lsu_araddr = 32'h8000_0030; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (lsu_rvalid) begin lat = 99; break; end
      if (lsu_wready) begin lat = n; break; end
    end
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    check("coll_wready_lat", 32'(lat), 32'd1);
    gap = -1;
    for (int n = 1; n < 20; n++) begin
      @(posedge clk); #1;
      if (lsu_wready) begin gap = 99; break; end
      if (lsu_rvalid) begin gap = n; rd = lsu_rdata; err = lsu_err; break; end
    end
    lsu_arvalid = 1'b0;
    check("coll_rvalid_gap", 32'(gap), 32'd3);
    check("coll_rdata", rd, 32'h1357_9BDF);
    check("coll_err", {31'd0, err}, 32'h0);
    @(posedge clk); #1;

    // Reset during WR_WAIT: nothing committed, outputs cleared at once.
    lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hDEAD_DEAD; lsu_wstrb = 8'h0f;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    #1;
    check("rst_rdata_cleared", lsu_rdata, 32'h0);
    gap = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (lsu_wready || lsu_rvalid || lsu_err) gap++;
    end
    check("rst_no_pulse", 32'(gap), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 32'h8000_0010, 32'h0, 8'h0f, rd, err, lat);
    check("rst_reread_data", rd, 32'hBEEF_1234);
    check("rst_reread_err", {31'd0, err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
